// File: rtl/data_mem_responder.sv
// Load/store responder: accepts one request, services it from word RAM after LAT
// cycles, and returns a one-cycle response with load data or an error flag.
module data_mem_responder #(
  parameter int DEPTH = 256,
  parameter int LAT   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mr,
  input  logic        mw,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  // Handshake: a request is accepted on a rising edge where req_valid && req_ready;
  // the response is a single rsp_valid cycle with no backpressure.

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        q_mr, q_mw;
  logic [2:0]  q_f3;
  logic [31:0] q_addr, q_wdata;
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            q_mr    <= mr;
            q_mw    <= mw;
            q_f3    <= funct3;
            q_addr  <= addr;
            q_wdata <= wdata;
            cnt     <= CNT_INIT;
            state   <= (LAT == 1) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_RESP;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  logic [1:0]    size;
  logic [1:0]    lane;
  logic          f3_ok, misalign, range_bad, req_err;
  logic [AW-1:0] idx;
  logic [31:0]   word, shifted, load_val, wsh;
  logic [3:0]    be_base, be;

  always_comb begin
    size      = q_f3[1:0];
    lane      = q_addr[1:0];
    // Stores have no unsigned variants, so funct3[2] must be clear for them.
    if (q_mw) f3_ok = !q_f3[2] && (size != 2'b11);
    else      f3_ok = (size != 2'b11) && !(q_f3[2] && size == 2'b10);
    misalign  = (size == 2'b01 && q_addr[0]) || (size == 2'b10 && lane != 2'b00);
    range_bad = |q_addr[31:AW+2];
    req_err   = (q_mr == q_mw) || !f3_ok || misalign || range_bad;

    idx     = q_addr[AW+1:2];
    word    = mem[idx];
    shifted = word >> {lane, 3'b000};
    case (size)
      2'b00:   load_val = {{24{~q_f3[2] & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{~q_f3[2] & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase

    case (size)
      2'b00:   be_base = 4'b0001;
      2'b01:   be_base = 4'b0011;
      default: be_base = 4'b1111;
    endcase
    be  = 4'(be_base << lane);
    wsh = q_wdata << {lane, 3'b000};
  end

  // Store commits on the edge that ends RESP; reset on that edge cancels it.
  always_ff @(posedge clk) begin
    if (rst_n && state == S_RESP && q_mw && !req_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wsh[i*8 +: 8];
      end
    end
  end

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign err       = rsp_valid && req_err;
  assign rdata     = (rsp_valid && q_mr && !req_err) ? load_val : 32'd0;
  assign dbg_state = state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: LAT=2 instance for data paths, errors and
// reset abort; LAT=1 instance for streaming throughput.
module tb_data_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        req_valid, mr, mw;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        req_ready, rsp_valid, err, busy;
  logic [31:0] rdata;
  logic [1:0]  dbg_state;

  logic        req_valid1, mr1, mw1;
  logic [2:0]  funct31;
  logic [31:0] addr1, wdata1;
  logic        req_ready1, rsp_valid1, err1, busy1;
  logic [31:0] rdata1;
  logic [1:0]  dbg_state1;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  data_mem_responder #(.DEPTH(256), .LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .mr(mr), .mw(mw), .funct3(funct3), .addr(addr), .wdata(wdata),
    .rsp_valid(rsp_valid), .rdata(rdata), .err(err), .busy(busy), .dbg_state(dbg_state)
  );

  data_mem_responder #(.DEPTH(256), .LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .mr(mr1), .mw(mw1), .funct3(funct31), .addr(addr1), .wdata(wdata1),
    .rsp_valid(rsp_valid1), .rdata(rdata1), .err(err1), .busy(busy1), .dbg_state(dbg_state1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: issue one request on dut and wait (bounded) for its response.
  task automatic do_req(input logic r, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int lat);
    @(negedge clk);
    req_valid = 1'b1; mr = r; mw = w; funct3 = f3; addr = a; wdata = d;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_before_accept: got %b want 1", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; mr = 1'b0; mw = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = rdata;
    e  = err;
  endtask

  task automatic check_load(input string name, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] exp);
    logic [31:0] rd; logic e; int lat;
    do_req(1'b1, 1'b0, f3, a, 32'h0, rd, e, lat);
    checks++;
    if (rd !== exp || e !== 1'b0 || lat != 2) begin
      errors++;
      $display("FAIL %s: rdata=%h err=%b lat=%0d want rdata=%h err=0 lat=2", name, rd, e, lat, exp);
    end
  endtask

  task automatic check_err(input string name, input logic r, input logic w,
                           input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] rd; logic e; int lat;
    do_req(r, w, f3, a, 32'h1234_5678, rd, e, lat);
    checks++;
    if (rd !== 32'h0 || e !== 1'b1 || lat != 2) begin
      errors++;
      $display("FAIL %s: rdata=%h err=%b lat=%0d want rdata=0 err=1 lat=2", name, rd, e, lat);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; mr = 1'b0; mw = 1'b0; funct3 = 3'b0; addr = 32'h0; wdata = 32'h0;
    req_valid1 = 1'b0; mr1 = 1'b0; mw1 = 1'b0; funct31 = 3'b0; addr1 = 32'h0; wdata1 = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, err, busy, rdata} !== {4'b1000, 32'h0}) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b rsp=%b err=%b busy=%b rdata=%h want 1 0 0 0 0",
               req_ready, rsp_valid, err, busy, rdata);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_store_load_word();
    logic [31:0] rd; logic e; int lat;
    do_req(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd, e, lat);
    checks++;
    if (rd !== 32'h0 || e !== 1'b0 || lat != 2) begin
      errors++;
      $display("FAIL sw_0x10: rdata=%h err=%b lat=%0d want 0 0 2", rd, e, lat);
    end
    check_load("lw_0x10", 3'b010, 32'h10, 32'hDEAD_BEEF);
  endtask

  task automatic test_subword_loads();
    check_load("lb_0x13",  3'b000, 32'h13, 32'hFFFF_FFDE);
    check_load("lbu_0x13", 3'b100, 32'h13, 32'h0000_00DE);
    check_load("lh_0x10",  3'b001, 32'h10, 32'hFFFF_BEEF);
    check_load("lhu_0x12", 3'b101, 32'h12, 32'h0000_DEAD);
  endtask

  task automatic test_byte_store();
    logic [31:0] rd; logic e; int lat;
    do_req(1'b0, 1'b1, 3'b000, 32'h11, 32'hAAAA_AA55, rd, e, lat);
    checks++;
    if (rd !== 32'h0 || e !== 1'b0 || lat != 2) begin
      errors++;
      $display("FAIL sb_0x11: rdata=%h err=%b lat=%0d want 0 0 2", rd, e, lat);
    end
    check_load("lw_after_sb", 3'b010, 32'h10, 32'hDEAD_55EF);
  endtask

  task automatic test_errors();
    check_err("err_lw_misaligned", 1'b1, 1'b0, 3'b010, 32'h12);
    check_err("err_sh_misaligned", 1'b0, 1'b1, 3'b001, 32'h11);
    check_err("err_mr_mw_both",    1'b1, 1'b1, 3'b010, 32'h10);
    check_err("err_mr_mw_none",    1'b0, 1'b0, 3'b010, 32'h10);
    check_err("err_funct3_011",    1'b1, 1'b0, 3'b011, 32'h10);
    check_err("err_store_sbu",     1'b0, 1'b1, 3'b100, 32'h10);
    check_err("err_out_of_range",  1'b1, 1'b0, 3'b010, 32'h400);
    check_load("lw_unchanged_after_errors", 3'b010, 32'h10, 32'hDEAD_55EF);
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] rd; logic e; int lat;
    bit saw_rsp;
    do_req(1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFE_F00D, rd, e, lat);
    @(negedge clk);
    req_valid = 1'b1; mr = 1'b0; mw = 1'b1; funct3 = 3'b010; addr = 32'h20; wdata = 32'h1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; mw = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, err, busy, rdata} !== {4'b1000, 32'h0}) begin
      errors++;
      $display("FAIL reset_mid_op_outputs: ready=%b rsp=%b err=%b busy=%b rdata=%h want 1 0 0 0 0",
               req_ready, rsp_valid, err, busy, rdata);
    end
    saw_rsp = 1'b0;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) saw_rsp = 1'b1;
    end
    checks++;
    if (saw_rsp) begin
      errors++;
      $display("FAIL reset_mid_op_no_rsp: rsp_valid seen=1 want 0");
    end
    check_load("lw_0x20_prior_value", 3'b010, 32'h20, 32'hCAFE_F00D);
  endtask

  // Streaming on the LAT=1 instance: req_valid held high, one accept every other cycle.
  task automatic stream_lat1(input logic r, input logic w, input logic [31:0] base,
                             input logic [31:0] dvals[3], input string name);
    logic [31:0] got;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (req_ready1 !== (c % 2 == 0) || busy1 !== (c % 2 == 1) || rsp_valid1 !== (c % 2 == 1)) begin
        errors++;
        $display("FAIL %s_handshake c=%0d: ready=%b busy=%b rsp=%b", name, c, req_ready1, busy1, rsp_valid1);
      end
      if (c % 2 == 1) begin
        got = exp_q.size() > 0 ? exp_q.pop_front() : 32'hX;
        checks++;
        if (rdata1 !== got || err1 !== 1'b0) begin
          errors++;
          $display("FAIL %s_rsp c=%0d: rdata=%h err=%b want %h 0", name, c, rdata1, err1, got);
        end
      end else begin
        req_valid1 = 1'b1; mr1 = r; mw1 = w; funct31 = 3'b010;
        addr1 = base + 32'(4 * (c / 2)); wdata1 = dvals[c/2];
        exp_q.push_back(r ? dvals[c/2] : 32'h0);
      end
    end
    @(negedge clk);
    req_valid1 = 1'b0; mr1 = 1'b0; mw1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals[3];
    vals[0] = 32'h1111_0001; vals[1] = 32'h2222_0002; vals[2] = 32'h3333_0003;
    exp_q.delete();
    stream_lat1(1'b0, 1'b1, 32'h40, vals, "b2b_store");
    stream_lat1(1'b1, 1'b0, 32'h40, vals, "b2b_load");
  endtask

  initial begin
    test_reset();
    test_store_load_word();
    test_subword_loads();
    test_byte_store();
    test_errors();
    test_reset_mid_op();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
